debug_uart_tx_fifo: RTL and testbench

DEBUG_UART_TX_FIFO -- requirements
Module: debug_uart_tx_fifo

---
 rtl/debug_uart_pkg.sv | 17 +
 rtl/byte_fifo.sv | 63 ++++++
 rtl/debug_uart_tx_fifo.sv | 136 +++++++++++++
 tb/tb_debug_uart_tx_fifo.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_uart_pkg.sv
// Shared types and helpers for the debug UART transmit path.
package debug_uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte queue with level-based full/empty; a pop frees a slot for a same-cycle push.
module byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok_c;
    logic          pop_ok_c;
    logic [LW-1:0] level_nxt_c;

    always_comb begin
        pop_ok_c    = pop && (level != '0);
        push_ok_c   = push && (!full || pop_ok_c);
        level_nxt_c = level;
        if (push_ok_c && !pop_ok_c) begin
            level_nxt_c = level + LW'(1);
        end else if (pop_ok_c && !push_ok_c) begin
            level_nxt_c = level - LW'(1);
        end
    end

    assign dout = mem[rd_ptr];

    // Storage carries no reset; only pointers and level define valid contents.
    always_ff @(posedge clk) begin
        if (push_ok_c && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_nxt_c;
            full  <= (level_nxt_c == LW'(DEPTH));
        end
    end

endmodule

// File: rtl/debug_uart_tx_fifo.sv
// CPU debug UART transmitter: byte FIFO feeding an 8N1 serializer with sticky overflow.
module debug_uart_tx_fifo
    import debug_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 25_000_000,
    parameter int unsigned BIT_RATE = 1_000_000,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     clr_ovf,
    output logic                     txd,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     ovf
);

    localparam int unsigned DIV   = calc_div(CLK_HZ, BIT_RATE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    tx_state_t        state;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift;
    logic [7:0]       head_c;
    logic             div_done_c;
    logic             queued_c;
    logic             pop_c;
    logic             push_ok_c;
    logic             drop_c;
    logic             idle_next_c;

    // Pop only at a frame boundary: from idle, or at the last stop-bit cycle.
    always_comb begin
        div_done_c  = (div_cnt == '0);
        queued_c    = (level != '0);
        pop_c       = queued_c && ((state == ST_IDLE) || ((state == ST_STOP) && div_done_c));
        push_ok_c   = wr_en && (!full || pop_c);
        drop_c      = wr_en && full && !pop_c;
        idle_next_c = !queued_c && ((state == ST_IDLE) || ((state == ST_STOP) && div_done_c));
    end

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (pop_c),
        .din   (wr_data),
        .dout  (head_c),
        .level (level),
        .full  (full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            txd     <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            busy    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            busy <= !idle_next_c || push_ok_c;

            if (drop_c) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    txd <= 1'b1;
                    if (pop_c) begin
                        shift   <= head_c;
                        div_cnt <= DIV_W'(DIV - 1);
                        txd     <= 1'b0;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (div_done_c) begin
                        div_cnt <= DIV_W'(DIV - 1);
                        bit_cnt <= 4'(DATA_BITS - 1);
                        txd     <= shift[0];
                        state   <= ST_DATA;
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                ST_DATA: begin
                    if (div_done_c) begin
                        div_cnt <= DIV_W'(DIV - 1);
                        if (bit_cnt == 4'd0) begin
                            txd   <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            txd     <= shift[1];
                            bit_cnt <= bit_cnt - 4'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                ST_STOP: begin
                    if (div_done_c) begin
                        // Next queued byte starts immediately so frames stay contiguous.
                        if (pop_c) begin
                            shift   <= head_c;
                            div_cnt <= DIV_W'(DIV - 1);
                            txd     <= 1'b0;
                            state   <= ST_START;
                        end else begin
                            txd   <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_uart_tx_fifo.sv
// Directed bench for debug_uart_tx_fifo at default parameters (DIV=25, DEPTH=8).
module tb_debug_uart_tx_fifo;

    localparam int DIV   = 25;
    localparam int FRAME = 10 * DIV;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic       txd;
    logic       full;
    logic [3:0] level;
    logic       busy;
    logic       ovf;

    int n_checks;
    int n_fail;

    debug_uart_tx_fifo #(
        .CLK_HZ   (25_000_000),
        .BIT_RATE (1_000_000),
        .DEPTH    (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .clr_ovf (clr_ovf),
        .txd     (txd),
        .full    (full),
        .level   (level),
        .busy    (busy),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line level for slot k of an 8N1 frame: 0 start, 1..8 data LSB first, 9 stop.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd got %b expected 1", txd); end
        n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d expected 0", level); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b expected 0", full); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b expected 0", ovf); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (txd !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset got txd=%b busy=%b expected txd=1 busy=0", txd, busy);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] b;
        logic e;
        b = 8'hA5;
        for (int t = 0; t <= 262; t++) begin
            if (t > 0) begin
                e = (t >= 2 && t < 2 + FRAME) ? exp_bit(b, (t - 2) / DIV) : 1'b1;
                n_checks++; if (txd !== e) begin n_fail++; $display("FAIL single_txd t=%0d got %b expected %b", t, txd, e); end
                if (t == 1) begin
                    n_checks++; if (level !== 4'd1 || busy !== 1'b1) begin
                        n_fail++; $display("FAIL single_queued got level=%0d busy=%b expected 1 1", level, busy);
                    end
                end
                if (t == 2) begin
                    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL single_popped got level=%0d expected 0", level); end
                end
                if (t == 251) begin
                    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_stop got %b expected 1", busy); end
                end
                if (t == 252) begin
                    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall got %b expected 0", busy); end
                end
            end
            wr_en = (t == 0);
            wr_data = b;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        logic e;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
        for (int t = 0; t <= 2 + 3 * FRAME + 10; t++) begin
            if (t > 0) begin
                e = (t >= 2 && t < 2 + 3 * FRAME) ? exp_bit(bytes[(t - 2) / FRAME], ((t - 2) % FRAME) / DIV) : 1'b1;
                n_checks++; if (txd !== e) begin n_fail++; $display("FAIL b2b_txd t=%0d got %b expected %b", t, txd, e); end
                if (t == 3) begin
                    n_checks++; if (level !== 4'd2) begin n_fail++; $display("FAIL b2b_level got %0d expected 2", level); end
                end
                if (t == 2 + 3 * FRAME) begin
                    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end got %b expected 0", busy); end
                end
            end
            wr_en = (t < 3);
            wr_data = bytes[(t < 3) ? t : 0];
            @(negedge clk);
        end
    endtask

    task automatic test_overflow();
        logic e;
        for (int t = 0; t <= 2 + 9 * FRAME + 300; t++) begin
            if (t > 0) begin
                e = (t >= 2 && t < 2 + 9 * FRAME) ? exp_bit(8'(16 + (t - 2) / FRAME), ((t - 2) % FRAME) / DIV) : 1'b1;
                n_checks++; if (txd !== e) begin n_fail++; $display("FAIL ovf_txd t=%0d got %b expected %b", t, txd, e); end
                if (t == 9) begin
                    n_checks++; if (ovf !== 1'b0 || full !== 1'b1) begin
                        n_fail++; $display("FAIL ovf_before_drop got ovf=%b full=%b expected 0 1", ovf, full);
                    end
                end
                if (t == 10) begin
                    n_checks++; if (level !== 4'd8 || full !== 1'b1 || ovf !== 1'b1) begin
                        n_fail++; $display("FAIL ovf_set got level=%0d full=%b ovf=%b expected 8 1 1", level, full, ovf);
                    end
                end
                if (t == 12) begin
                    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b expected 1", ovf); end
                end
                if (t == 13) begin
                    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b expected 0", ovf); end
                end
                if (t == 2 + 9 * FRAME) begin
                    n_checks++; if (busy !== 1'b0 || level !== 4'd0) begin
                        n_fail++; $display("FAIL ovf_drain got busy=%b level=%0d expected 0 0", busy, level);
                    end
                end
            end
            wr_en = (t < 10);
            wr_data = 8'(16 + ((t < 10) ? t : 0));
            clr_ovf = (t == 12);
            @(negedge clk);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] bytes [10];
        logic e;
        for (int i = 0; i < 9; i++) bytes[i] = 8'(3 * i + 1);
        bytes[9] = 8'hC3;
        for (int t = 0; t <= 2 + 10 * FRAME + 10; t++) begin
            if (t > 0) begin
                e = (t >= 2 && t < 2 + 10 * FRAME) ? exp_bit(bytes[(t - 2) / FRAME], ((t - 2) % FRAME) / DIV) : 1'b1;
                n_checks++; if (txd !== e) begin n_fail++; $display("FAIL fullpop_txd t=%0d got %b expected %b", t, txd, e); end
                if (t == 251) begin
                    n_checks++; if (level !== 4'd8 || full !== 1'b1) begin
                        n_fail++; $display("FAIL fullpop_pre got level=%0d full=%b expected 8 1", level, full);
                    end
                end
                if (t == 252) begin
                    n_checks++; if (level !== 4'd8 || full !== 1'b1 || ovf !== 1'b0) begin
                        n_fail++; $display("FAIL fullpop_post got level=%0d full=%b ovf=%b expected 8 1 0", level, full, ovf);
                    end
                end
                if (t == 2 + 10 * FRAME) begin
                    n_checks++; if (busy !== 1'b0 || ovf !== 1'b0) begin
                        n_fail++; $display("FAIL fullpop_end got busy=%b ovf=%b expected 0 0", busy, ovf);
                    end
                end
            end
            wr_en = (t < 9) || (t == 251);
            wr_data = (t < 9) ? bytes[t] : bytes[9];
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        logic e;
        b = 8'hF3;
        for (int t = 0; t <= 400; t++) begin
            if (t > 0 && t <= 110) begin
                e = (t >= 2) ? exp_bit(b, (t - 2) / DIV) : 1'b1;
                n_checks++; if (txd !== e) begin n_fail++; $display("FAIL rstmid_txd t=%0d got %b expected %b", t, txd, e); end
            end
            if (t == 111) begin
                n_checks++; if (txd !== 1'b1 || level !== 4'd0 || busy !== 1'b0 || full !== 1'b0) begin
                    n_fail++; $display("FAIL rstmid_abort got txd=%b level=%0d busy=%b full=%b expected 1 0 0 0", txd, level, busy, full);
                end
            end
            if (t > 111) begin
                n_checks++; if (txd !== 1'b1 || busy !== 1'b0) begin
                    n_fail++; $display("FAIL rstmid_quiet t=%0d got txd=%b busy=%b expected 1 0", t, txd, busy);
                end
            end
            rst = (t == 110);
            wr_en = (t < 3) || (t == 110);
            wr_data = (t == 0) ? b : 8'h81;
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        logic e;
        for (int t = 0; t <= 2 + 20 * FRAME + 10; t++) begin
            if (t > 0) begin
                e = (t >= 2 && t < 2 + 20 * FRAME) ? exp_bit(8'(37 * ((t - 2) / FRAME) + 5), ((t - 2) % FRAME) / DIV) : 1'b1;
                n_checks++; if (txd !== e) begin n_fail++; $display("FAIL wrap_txd t=%0d got %b expected %b", t, txd, e); end
                if (t == 1601) begin
                    n_checks++; if (level !== 4'd2) begin n_fail++; $display("FAIL wrap_level_mid got %0d expected 2", level); end
                end
                if (t == 3801) begin
                    n_checks++; if (level !== 4'd4) begin n_fail++; $display("FAIL wrap_level_late got %0d expected 4", level); end
                end
                if (t == 2 + 20 * FRAME) begin
                    n_checks++; if (busy !== 1'b0 || ovf !== 1'b0) begin
                        n_fail++; $display("FAIL wrap_end got busy=%b ovf=%b expected 0 0", busy, ovf);
                    end
                end
            end
            wr_en = (t % 200 == 0) && (t < 4000);
            wr_data = 8'(37 * (t / 200) + 5);
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        clr_ovf  = 1'b0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid_frame();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
